// File: rtl/lsu_mem_initiator.sv
// ============================================================================
//  Module   : lsu_mem_initiator
//  Summary  : Load/store initiator between EXU and the NPC data memory.
//             It accepts one request at a time and drives a single read or
//             write strobe. The read address and width are held through the
//             data cycle. Read data is sign- or zero-extended, and a
//             valid/ready response is returned to WBU.
//  Width codes (one-hot): Wdt8=0001, Wdt16=0010, Wdt32=0100, Wdt64=1000.
//  Option   : define LSU_MISALIGN_CHECK_EN to enable the alignment check at
//             accept. Misaligned accesses then bypass memory and respond
//             with resp_err=1.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lsu_mem_initiator #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int WDT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [WDT_W-1:0]  req_wdt,
    input  logic              req_uns,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [WDT_W-1:0]  wdt_op,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err
);

    localparam logic [WDT_W-1:0] c_wdt8  = WDT_W'(4'b0001);
    localparam logic [WDT_W-1:0] c_wdt16 = WDT_W'(4'b0010);
    localparam logic [WDT_W-1:0] c_wdt32 = WDT_W'(4'b0100);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_uns;
    logic              w_accept;
    logic              w_fault;
    logic [DATA_W-1:0] w_ext;

    assign w_accept = req_valid && req_ready;

`ifdef LSU_MISALIGN_CHECK_EN
    localparam logic [WDT_W-1:0] c_wdt64 = WDT_W'(4'b1000);
    // Only real memory accesses can fault; a nop never touches memory.
    assign w_fault = (req_load || req_store) &&
                     (((req_wdt == c_wdt16) && req_addr[0]) ||
                      ((req_wdt == c_wdt32) && (req_addr[1:0] != 2'b00)) ||
                      ((req_wdt == c_wdt64) && (req_addr[2:0] != 3'b000)));

    // Error flag is decided at accept and held through the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_err <= 1'b0;
        end else if (w_accept) begin
            resp_err <= w_fault;
        end
    end
`else
    assign w_fault  = 1'b0;
    assign resp_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe decode; strobes come straight off the state register.
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_fault) begin
                        w_next = RESP;
                    end else if (req_load) begin
                        w_next = RD_REQ;
                    end else if (req_store) begin
                        w_next = WR;
                    end else begin
                        w_next = RESP;
                    end
                end
            end
            RD_REQ: begin
                mem_ren = 1'b1;
                w_next  = RD_DATA;
            end
            RD_DATA: begin
                w_next = RESP;
            end
            WR: begin
                mem_wen = 1'b1;
                w_next  = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Extend the memory slice using the held width and the captured sign mode.
    always_comb begin
        w_ext = mem_rdata;
        case (wdt_op)
            c_wdt8: begin
                w_ext = {{(DATA_W-8){mem_rdata[7] & ~r_uns}}, mem_rdata[7:0]};
            end
            c_wdt16: begin
                w_ext = {{(DATA_W-16){mem_rdata[15] & ~r_uns}}, mem_rdata[15:0]};
            end
            c_wdt32: begin
                w_ext = {{(DATA_W-32){mem_rdata[31] & ~r_uns}}, mem_rdata[31:0]};
            end
            default: begin
                w_ext = mem_rdata;
            end
        endcase
    end

    // Capture the request at accept. Read address and width stay put until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_raddr <= '0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            wdt_op    <= '0;
            r_uns     <= 1'b0;
            resp_data <= '0;
        end else if (w_accept) begin
            r_uns     <= req_uns;
            resp_data <= '0;
            if (!w_fault && req_load) begin
                mem_raddr <= req_addr;
                wdt_op    <= req_wdt;
            end else if (!w_fault && req_store) begin
                mem_waddr <= req_addr;
                mem_wdata <= req_wdata;
                wdt_op    <= req_wdt;
            end
        end else if (r_state == RD_DATA) begin
            resp_data <= w_ext;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
`timescale 1ns/1ps

module tb_lsu_mem_initiator;

    localparam logic [3:0] W8 = 4'b0001, W16 = 4'b0010, W32 = 4'b0100, W64 = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic        req_load = 1'b0, req_store = 1'b0, req_uns = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wdt = W8;
    logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata, resp_data;
    logic        mem_ren, mem_wen, resp_valid, resp_err;
    logic        resp_ready = 1'b0;
    logic [3:0]  wdt_op;

    lsu_mem_initiator dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wdt(req_wdt), .req_uns(req_uns),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .wdt_op(wdt_op),
        .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_load;
        bit          is_store;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  wdt;
        logic [63:0] data;
        bit          err;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          stall = 1'b0;
    logic [63:0] last_resp;
    logic [7:0]  ref_mem [64];
    logic [7:0]  dev_mem [64];

    function automatic logic [7:0] init_byte(int i);
        return 8'(i * 37 + 11);
    endfunction

    function automatic int nbytes(logic [3:0] w);
        case (w)
            W8:      return 1;
            W16:     return 2;
            W32:     return 4;
            default: return 8;
        endcase
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event (t=%0t)", name, $time);
    endtask

    // Memory device: 64-byte window at 0x80000000, little-endian, address wraps.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) dev_mem[i] <= init_byte(i);
        end else if (mem_wen) begin
            for (int i = 0; i < 8; i++)
                if (i < nbytes(wdt_op))
                    dev_mem[6'(mem_waddr[5:0] + 6'(i))] <= mem_wdata[8*i +: 8];
        end
    end

    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < 8; i++)
            if (i < nbytes(wdt_op))
                mem_rdata[8*i +: 8] = dev_mem[6'(mem_raddr[5:0] + 6'(i))];
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            resp_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: follows the front of the expected queue and checks strobes and the response.
    bit in_txn = 0, seen_valid = 0, prev_ren = 0;
    int acc_cyc = 0, ren_cnt = 0, wen_cnt = 0;
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] m;
        if (rst) begin
            in_txn   = 0;
            prev_ren = 0;
        end else begin
            if (in_txn && exp_q.size() > 0) e = exp_q[0];
            if (mem_ren || mem_wen) chk("strobe_exclusive", 64'(mem_ren & mem_wen), 64'd0);
            if (mem_ren) begin
                if (!in_txn || !e.is_load || e.err) flag("spurious_mem_ren");
                else begin
                    chk("mem_raddr", mem_raddr, e.addr);
                    chk("wdt_op_rd", 64'(wdt_op), 64'(e.wdt));
                    ren_cnt++;
                end
            end
            if (prev_ren && in_txn) begin
                chk("mem_raddr_hold", mem_raddr, e.addr);
                chk("wdt_op_hold", 64'(wdt_op), 64'(e.wdt));
            end
            if (mem_wen) begin
                if (!in_txn || e.is_load || !e.is_store || e.err) flag("spurious_mem_wen");
                else begin
                    m = (nbytes(e.wdt) == 8) ? '1 : ((64'd1 << (8 * nbytes(e.wdt))) - 64'd1);
                    chk("mem_waddr", mem_waddr, e.addr);
                    chk("mem_wdata", mem_wdata & m, e.wdata & m);
                    chk("wdt_op_wr", 64'(wdt_op), 64'(e.wdt));
                    wen_cnt++;
                end
            end
            prev_ren = mem_ren;
            if (resp_valid) begin
                if (!in_txn) flag("spurious_resp_valid");
                else begin
                    if (!seen_valid) begin
                        chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
                        seen_valid = 1;
                    end
                    chk("resp_data", resp_data, e.data);
                    chk("resp_err", 64'(resp_err), 64'(e.err));
                    chk("req_ready_in_resp", 64'(req_ready), 64'd0);
                    if (resp_ready) begin
                        chk("ren_pulses", 64'(ren_cnt), 64'(e.is_load && !e.err));
                        chk("wen_pulses", 64'(wen_cnt), 64'(!e.is_load && e.is_store && !e.err));
                        last_resp = resp_data;
                        void'(exp_q.pop_front());
                        in_txn = 0;
                    end
                end
            end
            if (req_valid && req_ready) begin
                if (in_txn) flag("accept_while_busy");
                if (exp_q.size() == 0) flag("accept_without_request");
                in_txn     = 1;
                seen_valid = 0;
                acc_cyc    = cyc;
                ren_cnt    = 0;
                wen_cnt    = 0;
            end
        end
    end

    // Reference model: computes the response from the byte-array view of memory.
    task automatic issue(bit ld, bit st, logic [63:0] addr, logic [63:0] wd,
                         logic [3:0] wdt, bit uns);
        exp_t        e;
        int          n;
        logic [63:0] v;
        bit          ok;
        n = nbytes(wdt);
        v = '0;
        e.is_load = ld; e.is_store = st; e.addr = addr; e.wdata = wd; e.wdt = wdt;
        e.err = 0;
`ifdef LSU_MISALIGN_CHECK_EN
        if ((ld || st) && (addr % 64'(n)) != 0) e.err = 1;
`endif
        if (e.err) begin
            e.data = '0; e.lat = 1;
        end else if (ld) begin
            for (int i = 0; i < n; i++)
                v = v | (64'(ref_mem[(int'(addr[5:0]) + i) % 64]) << (8 * i));
            if (!uns && n < 8 && v[8*n-1]) v = v - (64'd1 << (8 * n));
            e.data = v; e.lat = 3;
        end else if (st) begin
            for (int i = 0; i < n; i++)
                ref_mem[(int'(addr[5:0]) + i) % 64] = wd[8*i +: 8];
            e.data = '0; e.lat = 2;
        end else begin
            e.data = '0; e.lat = 1;
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1; req_load = ld; req_store = st; req_addr = addr;
        req_wdata = wd; req_wdt = wdt; req_uns = uns;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) flag("accept_timeout");
        @(posedge clk); #1;
        req_valid = 0; req_load = $urandom_range(0, 1); req_store = $urandom_range(0, 1);
        req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
        req_uns = $urandom_range(0, 1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) begin flag("response_timeout"); exp_q.delete(); end
    endtask

    initial begin
        logic [3:0]  w;
        logic [63:0] off;
        int          r;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_byte(i);
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_mem_ren", 64'(mem_ren), 64'd0);
        chk("rst_mem_wen", 64'(mem_wen), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_mem_raddr", mem_raddr, 64'd0);
        chk("rst_mem_waddr", mem_waddr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_wdt_op", 64'(wdt_op), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);

        // Directed cases.
        issue(0, 1, 64'h8000_0004, 64'h0000_0000_FFFF_8000, W32, 0);
        issue(1, 0, 64'h8000_0004, '0, W32, 0);
        wait_idle();
        chk("lw_sign", last_resp, 64'hFFFF_FFFF_FFFF_8000);
        issue(0, 1, 64'h8000_0007, 64'h9C, W8, 0);
        issue(1, 0, 64'h8000_0007, '0, W8, 1);
        wait_idle();
        chk("lbu_zero", last_resp, 64'h9C);
        issue(0, 1, 64'h8000_0010, 64'h1122_3344_5566_7788, W64, 0);
        issue(1, 0, 64'h8000_0010, '0, W64, 0);
        wait_idle();
        chk("ld_pass", last_resp, 64'h1122_3344_5566_7788);
        issue(1, 0, 64'h8000_0001, '0, W16, 0);
        issue(0, 0, 64'h8000_0003, '0, W32, 0);
        issue(1, 1, 64'h8000_0008, 64'hDEAD, W16, 0);
        wait_idle();

        // Response held off for five cycles.
        stall = 1;
        issue(0, 1, 64'h8000_0020, 64'hCAFE_F00D, W32, 0);
        r = 0;
        for (int k = 0; k < 20 && !resp_valid; k++) @(negedge clk);
        if (!resp_valid) flag("stall_no_resp");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_resp_valid", 64'(resp_valid), 64'd1);
            chk("stall_strobes", 64'(mem_ren | mem_wen), 64'd0);
            chk("stall_req_ready", 64'(req_ready), 64'd0);
        end
        stall = 0;
        wait_idle();

        // Reset during the read-data cycle drops the load.
        issue(1, 0, 64'h8000_0008, '0, W64, 0);
        @(posedge clk); #1;
        chk("rd_data_ren_low", 64'(mem_ren), 64'd0);
        rst = 1;
        exp_q.delete();
        @(posedge clk); #1;
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_mem_ren", 64'(mem_ren), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        rst = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_byte(i);
        repeat (6) @(negedge clk);

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 3))
                0: w = W8;
                1: w = W16;
                2: w = W32;
                default: w = W64;
            endcase
            off = 64'($urandom_range(0, 63));
            if ($urandom_range(0, 4) != 0) off = off & ~64'(nbytes(w) - 1);
            r = $urandom_range(0, 19);
            issue(r < 9 || r == 19, (r >= 9 && r < 18) || r == 19, 64'h8000_0000 + off,
                  {$urandom, $urandom}, w, $urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
        end
        wait_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
